// File: rtl/aes_req_arbiter_pkg.sv
// rtl/aes_req_arbiter_pkg.sv - shared types and helpers for the AES request arbiter
package aes_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        KEY_CHK,
        KEY,
        KEY_WAIT,
        BLK,
        BLK_WAIT,
        RESP
    } arb_state_t;

    // Grant index width; never below one bit so a single-bit index is always legal.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/aes_req_arbiter_if.sv
// rtl/aes_req_arbiter_if.sv - requester-side request/response bundle for the AES arbiter
interface aes_req_arbiter_if #(
    parameter int NREQ  = 2,
    parameter int KEY_W = 256,
    parameter int BLK_W = 128
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*KEY_W-1:0] req_key;
    logic [NREQ-1:0]       req_rekey;
    logic [NREQ-1:0]       req_encdec;
    logic [NREQ*BLK_W-1:0] req_block;
    logic [NREQ-1:0]       resp_valid;
    logic [NREQ-1:0]       resp_ready;
    logic [BLK_W-1:0]      resp_block;

    modport master (
        output req_valid, req_key, req_rekey, req_encdec, req_block, resp_ready,
        input  req_ready, resp_valid, resp_block
    );

    modport slave (
        input  req_valid, req_key, req_rekey, req_encdec, req_block, resp_ready,
        output req_ready, resp_valid, resp_block
    );
endinterface

// File: rtl/aes_req_arbiter_rr_pick.sv
// rtl/aes_req_arbiter_rr_pick.sv - combinational round-robin pick starting after last_grant
module rr_pick
    import aes_arb_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int GW   = clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [GW-1:0]   last_grant,
    output logic [GW-1:0]   idx,
    output logic            found
);
    logic [GW-1:0] cand;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = last_grant;
        for (int k = 0; k < NREQ; k++) begin
            cand = (cand == GW'(NREQ - 1)) ? '0 : cand + 1'b1;
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end
endmodule

// File: rtl/aes_req_arbiter.sv
// rtl/aes_req_arbiter.sv - round-robin sequencer of one shared AES core among NREQ requesters
module aes_req_arbiter
    import aes_arb_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int KEY_W = 256,
    parameter int BLK_W = 128
) (
    input  logic               clk,
    input  logic               rst_n,
    aes_req_arbiter_if.slave   rq,
    output logic               core_init,
    output logic               core_next,
    output logic               core_encdec,
    output logic [KEY_W-1:0]   core_key,
    output logic [BLK_W-1:0]   core_block,
    input  logic               core_ready,
    input  logic               core_result_valid,
    input  logic [BLK_W-1:0]   core_result,
    output logic               busy
);
    localparam int GW = clog2(NREQ);

    arb_state_t    state;
    logic [GW-1:0] grant;
    logic [GW-1:0] last_grant;
    logic [GW-1:0] key_owner;
    logic          key_owner_valid;
    logic          rekey_q;
    logic [GW-1:0] pick_idx;
    logic          pick_found;

    logic [KEY_W-1:0] key_arr [NREQ];
    logic [BLK_W-1:0] blk_arr [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign key_arr[g] = rq.req_key[g*KEY_W +: KEY_W];
        assign blk_arr[g] = rq.req_block[g*BLK_W +: BLK_W];
    end

    rr_pick #(.NREQ(NREQ), .GW(GW)) u_pick (
        .req        (rq.req_valid),
        .last_grant (last_grant),
        .idx        (pick_idx),
        .found      (pick_found)
    );

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            grant           <= '0;
            last_grant      <= GW'(NREQ - 1);
            key_owner       <= '0;
            key_owner_valid <= 1'b0;
            rekey_q         <= 1'b0;
            core_init       <= 1'b0;
            core_next       <= 1'b0;
            core_encdec     <= 1'b0;
            core_key        <= '0;
            core_block      <= '0;
            rq.req_ready    <= '0;
            rq.resp_valid   <= '0;
            rq.resp_block   <= '0;
        end else begin
            rq.req_ready <= '0;
            core_init    <= 1'b0;
            core_next    <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        grant        <= pick_idx;
                        rq.req_ready <= NREQ'(1) << pick_idx;
                        core_key     <= key_arr[pick_idx];
                        core_block   <= blk_arr[pick_idx];
                        core_encdec  <= rq.req_encdec[pick_idx];
                        rekey_q      <= rq.req_rekey[pick_idx];
                        state        <= KEY_CHK;
                    end
                end
                KEY_CHK: begin
                    // Encrypt and decrypt share one expansion, so only owner and rekey matter.
                    if (key_owner_valid && key_owner == grant && !rekey_q) state <= BLK;
                    else state <= KEY;
                end
                KEY: begin
                    if (core_ready) begin
                        core_init <= 1'b1;
                        state     <= KEY_WAIT;
                    end
                end
                KEY_WAIT: begin
                    // The pulse cycle itself is skipped: core_ready has not dropped yet.
                    if (!core_init && core_ready) begin
                        key_owner       <= grant;
                        key_owner_valid <= 1'b1;
                        state           <= BLK;
                    end
                end
                BLK: begin
                    if (core_ready) begin
                        core_next <= 1'b1;
                        state     <= BLK_WAIT;
                    end
                end
                BLK_WAIT: begin
                    if (!core_next && core_result_valid) begin
                        rq.resp_block <= core_result;
                        rq.resp_valid <= NREQ'(1) << grant;
                        state         <= RESP;
                    end
                end
                RESP: begin
                    if (rq.resp_ready[grant]) begin
                        rq.resp_valid <= '0;
                        last_grant    <= grant;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_req_arbiter.sv
// tb/tb_aes_req_arbiter.sv - scoreboard bench for aes_req_arbiter with a behavioural AES core model
module tb_aes_req_arbiter;
    localparam int NREQ  = 2;
    localparam int KEY_W = 256;
    localparam int BLK_W = 128;

    localparam logic [255:0] K_FIPS  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] B_FIPS  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_FIPS = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [255:0] K_A     = 256'h5a5a_1234_0000_ffff_dead_beef_cafe_f00d_0123_4567_89ab_cdef_0f1e_2d3c_4b5a_6978;
    localparam logic [255:0] K_B     = 256'h1111_2222_3333_4444_5555_6666_7777_8888_9999_aaaa_bbbb_cccc_dddd_eeee_ffff_0000;

    logic clk = 1'b0;
    logic rst_n;
    logic core_init, core_next, core_encdec, core_ready, core_result_valid, busy;
    logic [KEY_W-1:0] core_key;
    logic [BLK_W-1:0] core_block, core_result;

    aes_req_arbiter_if #(.NREQ(NREQ), .KEY_W(KEY_W), .BLK_W(BLK_W)) rif ();

    aes_req_arbiter #(.NREQ(NREQ), .KEY_W(KEY_W), .BLK_W(BLK_W)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .rq                (rif.slave),
        .core_init         (core_init),
        .core_next         (core_next),
        .core_encdec       (core_encdec),
        .core_key          (core_key),
        .core_block        (core_block),
        .core_ready        (core_ready),
        .core_result_valid (core_result_valid),
        .core_result       (core_result),
        .busy              (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Stand-in for AES: the FIPS-197 AES-256 vector is honoured exactly, all else is a keyed mix.
    function automatic logic [127:0] aes_ref(input logic [255:0] k, input logic [127:0] b, input logic e);
        if (k == K_FIPS && b == B_FIPS && e) return CT_FIPS;
        return ({b[126:0], b[127]} ^ k[127:0] ^ k[255:128]) + (e ? 128'd5 : 128'd9);
    endfunction

    // Core model: remembers the key given at init, answers next after a random latency.
    logic [255:0] cm_key;
    logic [127:0] cm_blk, cm_res;
    logic         cm_ed, cm_ready, cm_rv;
    int           cm_cnt, cm_mode;

    assign core_ready        = cm_ready;
    assign core_result_valid = cm_rv;
    assign core_result       = cm_res;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cm_ready <= 1'b1; cm_rv <= 1'b0; cm_cnt <= 0; cm_mode <= 0;
            cm_key <= '0; cm_blk <= '0; cm_ed <= 1'b0; cm_res <= '0;
        end else begin
            cm_rv <= 1'b0;
            if (cm_mode == 0) begin
                if (core_init) begin
                    cm_key <= core_key; cm_ready <= 1'b0; cm_mode <= 1;
                    cm_cnt <= int'($urandom_range(5, 2));
                end else if (core_next) begin
                    cm_blk <= core_block; cm_ed <= core_encdec; cm_ready <= 1'b0; cm_mode <= 2;
                    cm_cnt <= int'($urandom_range(6, 2));
                end
            end else if (cm_cnt > 1) begin
                cm_cnt <= cm_cnt - 1;
            end else begin
                cm_ready <= 1'b1;
                if (cm_mode == 2) begin
                    cm_rv  <= 1'b1;
                    cm_res <= aes_ref(cm_key, cm_blk, cm_ed);
                end
                cm_mode <= 0;
            end
        end
    end

    // Reference model and scoreboard.
    typedef struct { int who; logic [127:0] res; } exp_t;
    exp_t sb_q[$];
    int   ref_last = NREQ - 1;
    int   ref_owner = 0;
    bit   ref_owner_v = 0;
    bit   tx_active = 0, tx_need_init = 0;
    int   tx_cyc, tx_inits, tx_nexts, tx_next_cyc;
    int   hold_cnt = 0;
    logic [127:0] last_resp = '0;
    logic [NREQ-1:0]       prev_valid = '0, prev_rekey = '0, prev_ed = '0;
    logic [NREQ*KEY_W-1:0] prev_key = '0;
    logic [NREQ*BLK_W-1:0] prev_blk = '0;
    logic                  prev_crv = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            ref_last = NREQ - 1; ref_owner_v = 0; sb_q.delete(); tx_active = 0;
        end else begin
            if (core_init || core_next) begin
                chk("core_strobe_excl", 256'(core_init && core_next), 256'(0));
                chk("core_strobe_ready", 256'(core_ready), 256'(1));
            end
            if (prev_crv) chk("resp_latency", 256'(|rif.resp_valid), 256'(1));
            if (tx_active) begin
                tx_cyc++;
                if (core_init) tx_inits++;
                if (core_next) begin tx_nexts++; tx_next_cyc = tx_cyc; end
            end
            if (rif.resp_valid != '0) begin
                if (sb_q.size() == 0) begin
                    chk("spurious_resp", 256'(rif.resp_valid), 256'(0));
                end else begin
                    chk("resp_route", 256'(rif.resp_valid), 256'(1 << sb_q[0].who));
                    chk("resp_block", 256'(rif.resp_block), 256'(sb_q[0].res));
                    if (rif.resp_valid[1] && !rif.resp_ready[1]) hold_cnt++;
                    if ((rif.resp_valid & rif.resp_ready) != '0) begin
                        exp_t e;
                        e = sb_q.pop_front();
                        chk("init_count", 256'(tx_inits), 256'(tx_need_init ? 1 : 0));
                        chk("next_count", 256'(tx_nexts), 256'(1));
                        if (!tx_need_init) chk("reuse_latency", 256'(tx_next_cyc), 256'(2));
                        ref_last  = e.who;
                        last_resp = rif.resp_block;
                        tx_active = 0;
                    end
                end
            end
            if (rif.req_ready != '0) begin
                int  pick;
                bit  found;
                found = 0; pick = 0;
                for (int k = 1; k <= NREQ; k++) begin
                    int c;
                    c = (ref_last + k) % NREQ;
                    if (!found && prev_valid[c]) begin found = 1; pick = c; end
                end
                chk("grant_pick", 256'(rif.req_ready), found ? 256'(1 << pick) : 256'(0));
                chk("grant_while_busy", 256'(sb_q.size() + (tx_active ? 1 : 0)), 256'(0));
                if (found) begin
                    exp_t e;
                    e.who = pick;
                    e.res = aes_ref(prev_key[pick*KEY_W +: KEY_W], prev_blk[pick*BLK_W +: BLK_W], prev_ed[pick]);
                    sb_q.push_back(e);
                    tx_need_init = !ref_owner_v || ref_owner != pick || prev_rekey[pick];
                    ref_owner = pick; ref_owner_v = 1;
                    tx_active = 1; tx_cyc = 0; tx_inits = 0; tx_nexts = 0; tx_next_cyc = -1;
                end
            end
        end
        prev_valid = rif.req_valid; prev_rekey = rif.req_rekey; prev_ed = rif.req_encdec;
        prev_key = rif.req_key; prev_blk = rif.req_block; prev_crv = core_result_valid;
    end

    // Response-ready driver.
    bit rand_mode = 0;
    bit hold1 = 0;
    initial begin
        rif.resp_ready = '1;
        forever begin
            @(posedge clk); #1;
            rif.resp_ready = rand_mode ? NREQ'($urandom) : '1;
            if (hold1) rif.resp_ready[1] = 1'b0;
        end
    end

    task automatic do_req(input int i, input logic [255:0] k, input logic [127:0] b,
                          input logic ed, input logic rk);
        bit got;
        got = 0;
        rif.req_key[i*KEY_W +: KEY_W] = k;
        rif.req_block[i*BLK_W +: BLK_W] = b;
        rif.req_encdec[i] = ed;
        rif.req_rekey[i] = rk;
        rif.req_valid[i] = 1'b1;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            if (rif.req_ready[i]) begin got = 1; break; end
        end
        chk("req_accept_timeout", 256'(got), 256'(1));
        rif.req_valid[i] = 1'b0;
    endtask

    task automatic wait_idle();
        bit done;
        done = 0;
        for (int c = 0; c < 600; c++) begin
            @(posedge clk); #1;
            if (sb_q.size() == 0 && !tx_active && !busy && rif.req_valid == '0) begin done = 1; break; end
        end
        chk("drain_timeout", 256'(done), 256'(1));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, 256'(rif.req_ready), 256'(0));
        chk({tag, "_resp_valid"}, 256'(rif.resp_valid), 256'(0));
        chk({tag, "_core_init"}, 256'(core_init), 256'(0));
        chk({tag, "_core_next"}, 256'(core_next), 256'(0));
        chk({tag, "_busy"}, 256'(busy), 256'(0));
        chk({tag, "_resp_block"}, 256'(rif.resp_block), 256'(0));
        chk({tag, "_core_key"}, core_key, 256'(0));
        chk({tag, "_core_block"}, 256'(core_block), 256'(0));
        chk({tag, "_core_encdec"}, 256'(core_encdec), 256'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        rst_n = 1'b0;
        rif.req_valid = '0; rif.req_key = '0; rif.req_block = '0;
        rif.req_rekey = '0; rif.req_encdec = '0;
        repeat (3) @(posedge clk);
        #1 check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        do_req(0, K_FIPS, B_FIPS, 1'b1, 1'b0);
        wait_idle();
        chk("fips_result", 256'(last_resp), 256'(CT_FIPS));

        do_req(0, K_FIPS, B_FIPS, 1'b1, 1'b0);
        wait_idle();
        chk("fips_repeat", 256'(last_resp), 256'(CT_FIPS));

        do_req(0, K_FIPS, B_FIPS, 1'b1, 1'b1);
        wait_idle();

        fork
            for (int n = 0; n < 4; n++) do_req(0, K_A, {$urandom, $urandom, $urandom, $urandom}, 1'($urandom), 1'b0);
            for (int n = 0; n < 4; n++) do_req(1, K_B, {$urandom, $urandom, $urandom, $urandom}, 1'($urandom), 1'b0);
        join
        wait_idle();

        hold_cnt = 0;
        hold1 = 1;
        do_req(1, K_B, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0);
        fork
            do_req(0, K_A, {$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b0);
            begin
                seen = 0;
                for (int c = 0; c < 200; c++) begin
                    @(posedge clk); #1;
                    if (rif.resp_valid[1]) begin seen = 1; break; end
                end
                chk("hold_resp_seen", 256'(seen), 256'(1));
                repeat (20) @(posedge clk);
                #1 hold1 = 0;
            end
        join
        wait_idle();
        chk("hold_cycles", 256'(hold_cnt >= 19), 256'(1));

        do_req(0, K_A, {$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b0);
        seen = 0;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk); #1;
            if (core_next) begin seen = 1; break; end
        end
        chk("reset_test_next_seen", 256'(seen), 256'(1));
        @(posedge clk); #1;
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midrst");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        do_req(0, K_A, {$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b0);
        wait_idle();

        rand_mode = 1;
        fork
            for (int n = 0; n < 12; n++) begin
                repeat ($urandom_range(3, 0)) @(posedge clk);
                #1 do_req(0, ($urandom_range(1, 0) != 0) ? K_A : K_B, {$urandom, $urandom, $urandom, $urandom},
                          1'($urandom), ($urandom_range(3, 0) == 0));
            end
            for (int n = 0; n < 12; n++) begin
                repeat ($urandom_range(3, 0)) @(posedge clk);
                #1 do_req(1, ($urandom_range(1, 0) != 0) ? K_A : K_B, {$urandom, $urandom, $urandom, $urandom},
                          1'($urandom), ($urandom_range(3, 0) == 0));
            end
        join
        wait_idle();
        rand_mode = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/aes_req_arbiter.md
# aes_req_arbiter

Sequences a single shared AES core (init/next/ready/result_valid style handshake) between `NREQ` block-level requesters. Each requester presents a key, a data block and an encrypt/decrypt flag. The arbiter grants one request at a time in round-robin order, reloads the key only when needed, runs one block, and returns the result to the granted requester. It sits between the CSR/DMA requesters and the AES core in the crypto subsystem.

## Interface
- `NREQ`, 2: number of requesters (2..4).
- `KEY_W`, 256: key width; the core's `keylen` is tied high for 256, low for 128.
- `BLK_W`, 128: block width.
- `clk` input 1: sole clock; all logic is rising-edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req_valid` input NREQ: per-requester request valid.
- `req_ready` output NREQ: one-hot accept strobe, one cycle.
- `req_key` input NREQ*KEY_W: packed keys, requester i at [i*KEY_W +: KEY_W].
- `req_rekey` input NREQ: force a key reload for this request.
- `req_encdec` input NREQ: 1 = encrypt, 0 = decrypt.
- `req_block` input NREQ*BLK_W: packed input blocks.
- `resp_valid` output NREQ: one-hot result valid.
- `resp_ready` input NREQ: requester accepts the result.
- `resp_block` output BLK_W: result block, shared by all requesters.
- `core_init` output 1: one-cycle key-expansion start.
- `core_next` output 1: one-cycle block start.
- `core_encdec`, `core_key`, `core_block` output 1/KEY_W/BLK_W: registered operands to the core.
- `core_ready` input 1: core idle.
- `core_result_valid` input 1: result valid.
- `core_result` input BLK_W: result data.
- `busy` output 1: high whenever the FSM is not in IDLE.

## Operation
- FSM states:
  - IDLE: with any `req_valid` set, grant the first set requester at or after `last_grant+1` (mod NREQ). Pulse that `req_ready` bit, capture key, block, encdec and rekey into operand registers, then go to KEY_CHK.
  - KEY_CHK: if `key_owner_valid && key_owner==grant && !rekey_q`, go to BLK. Otherwise go to KEY.
  - KEY: wait for `core_ready`, pulse `core_init` for one cycle, then go to KEY_WAIT.
  - KEY_WAIT: wait at least one cycle after the init pulse, then until `core_ready`=1. Then set `key_owner=grant`, `key_owner_valid=1`, go to BLK.
  - BLK: wait for `core_ready`, pulse `core_next`, go to BLK_WAIT.
  - BLK_WAIT: on `core_result_valid` (sampled no earlier than one cycle after `core_next`), latch `core_result` into `resp_block`, go to RESP.
  - RESP: hold `resp_valid[grant]`=1 and `resp_block` stable until `resp_ready[grant]`. Then update `last_grant=grant` and return to IDLE.
- Operand registers are loaded only in the IDLE grant cycle. Requester inputs may change after `req_ready`.
- `resp_ready` bits of non-granted requesters are ignored. `req_valid` arriving outside IDLE waits; it is never dropped or acknowledged.
- `key_owner_valid` clears on reset only. A different encdec does not force a rekey, because the core expands both directions from one init.

## Timing
- Reset values:
  - `req_ready`, `resp_valid`, `core_init`, `core_next`, `busy`: 0.
  - `resp_block`, `core_key`, `core_block`, `core_encdec`: 0.
  - `last_grant`: NREQ-1, so requester 0 wins first.
  - FSM: IDLE. `key_owner_valid`: 0.
- Grant latency: `req_ready` is asserted in the cycle after `req_valid` is first seen in IDLE. Minimum arbiter overhead is 2 cycles grant-to-`core_next` when the key is reused.
- `core_init` and `core_next` are never high in the same cycle, and are never high while `core_ready`=0.
- `resp_valid` asserts the cycle after `core_result_valid`. Back-to-back requests: the next grant occurs the cycle after the `resp_valid && resp_ready` handshake.
- Reset mid-operation: all state is cleared immediately. An in-flight core operation is abandoned, and no `resp_valid` is issued for it.
- Simultaneous requests: strict round-robin. A requester holding `req_valid` continuously is granted within NREQ grants.

## Structure
- Shared package `aes_arb_pkg`:
  - FSM state enum (IDLE, KEY_CHK, KEY, KEY_WAIT, BLK, BLK_WAIT, RESP).
  - Grant-index width function `clog2(NREQ)`.
- One sub-module, `rr_pick`: combinational round-robin pick. Inputs are the request vector and `last_grant`; outputs are the grant index and a found flag. Everything else stays in the top module.

## Test plan
- Reset, then requester 0 alone with key K0, rekey=0, encrypt FIPS-197 block 00112233…eeff under AES-256 → `core_init` once, then `core_next` once, `resp_block`=8ea2b7ca516745bfeafc49904b496089, `resp_valid[0]` only.
- Requester 0 repeats the same request with rekey=0 → no `core_init`; `core_next` 2 cycles after `req_ready`; same result.
- Requester 0 with rekey=1 → `core_init` is issued despite the same owner.
- Both requesters hold `req_valid` for 4 requests each → grant order 0,1,0,1,…. Every switch issues `core_init`, and each result routes to the correct `resp_valid` bit.
- Requester 1 holds `resp_ready`=0 for 20 cycles while requester 0 requests → `resp_block` is stable, no new grant, and `req_ready[0]` waits until the handshake.
- `rst_n` low during BLK_WAIT → all outputs at reset values within the same cycle, no `resp_valid` afterward, and the next request triggers `core_init`.
